// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the half/full precision multiplier scheduler.
package mult_sched_pkg;
  localparam int LANE_W = 4;
  localparam int PROD_W = 16;

  typedef enum logic {EMPTY = 1'b0, HALF_HELD = 1'b1} sched_state_t;

  typedef struct packed {
    logic [LANE_W-1:0] a_nib;
    logic [LANE_W-1:0] b_nib;
  } hold_t;

  localparam logic [1:0] LANES_FULL = 2'b11;
  localparam logic [1:0] LANES_PAIR = 2'b11;
  localparam logic [1:0] LANES_LONE = 2'b01;
endpackage

// File: rtl/config_multiplier_8bit.sv
// Combinational signed multiplier: one 8x8 product, or two independent 4x4 lanes
// packed as {lane1[7:0], lane0[7:0]} when halvedPrecision is set.
module config_multiplier_8bit (
  input  logic [7:0]  multiplier,
  input  logic [7:0]  multiplicand,
  input  logic        halvedPrecision,
  output logic [15:0] product
);
  logic signed [15:0] w_a16, w_b16, w_full;
  logic signed [7:0]  w_a0, w_b0, w_a1, w_b1, w_lane0, w_lane1;

  assign w_a16  = {{8{multiplier[7]}}, multiplier};
  assign w_b16  = {{8{multiplicand[7]}}, multiplicand};
  assign w_full = w_a16 * w_b16;

  // Each lane is sign-extended to 8 bits so the product cannot overflow its lane
  assign w_a0    = {{4{multiplier[3]}}, multiplier[3:0]};
  assign w_b0    = {{4{multiplicand[3]}}, multiplicand[3:0]};
  assign w_a1    = {{4{multiplier[7]}}, multiplier[7:4]};
  assign w_b1    = {{4{multiplicand[7]}}, multiplicand[7:4]};
  assign w_lane0 = w_a0 * w_b0;
  assign w_lane1 = w_a1 * w_b1;

  assign product = halvedPrecision ? {w_lane1, w_lane0} : w_full;
endmodule

// File: rtl/mult_pair_scheduler.sv
// Packs half-precision requests two per multiplier issue; full requests issue alone.
// Optional MULT_PAIR_STATS_EN adds per-kind issue counters.
module mult_pair_scheduler
  import mult_sched_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 8
`ifdef MULT_PAIR_STATS_EN
  , parameter int CNT_W = 16
`endif
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  input  logic              in_half,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_half,
  output logic [1:0]        out_lanes
`ifdef MULT_PAIR_STATS_EN
  , output logic [CNT_W-1:0] stat_full
  , output logic [CNT_W-1:0] stat_pair
  , output logic [CNT_W-1:0] stat_lone
`endif
);
  localparam logic [7:0] TO_LAST = 8'(FLUSH_TIMEOUT - 1);

  sched_state_t      r_state, w_next_state;
  hold_t             r_hold;
  logic [7:0]        r_cnt;
  logic              r_out_valid, r_out_half;
  logic [PROD_W-1:0] r_out_product;
  logic [1:0]        r_out_lanes;

  logic              w_can_issue, w_in_ready, w_hold_load, w_issue;
  logic              w_issue_full, w_issue_pair, w_issue_lone;
  logic [7:0]        w_mult, w_mcand;
  logic              w_halved;
  logic [1:0]        w_lanes;
  logic [PROD_W-1:0] w_product;

  // Both streams: a transfer happens on a cycle where valid && ready at the rising edge;
  // the source holds its payload steady while valid && !ready.
  assign w_can_issue = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY:     if (w_hold_load) w_next_state = HALF_HELD;
      HALF_HELD: if (w_issue_pair || w_issue_lone) w_next_state = EMPTY;
      default:   w_next_state = EMPTY;
    endcase
  end

  // A pairing half request outranks every flush trigger in HALF_HELD
  always_comb begin
    w_in_ready   = 1'b0;
    w_hold_load  = 1'b0;
    w_issue_full = 1'b0;
    w_issue_pair = 1'b0;
    w_issue_lone = 1'b0;
    w_mult       = in_a;
    w_mcand      = in_b;
    w_halved     = 1'b0;
    w_lanes      = LANES_FULL;
    case (r_state)
      EMPTY: begin
        w_in_ready   = w_can_issue;
        w_issue_full = in_valid && w_can_issue && !in_half;
        w_hold_load  = in_valid && w_can_issue && in_half;
      end
      HALF_HELD: begin
        w_halved     = 1'b1;
        w_issue_pair = in_valid && in_half && w_can_issue;
        w_issue_lone = !w_issue_pair && w_can_issue &&
                       ((in_valid && !in_half) || flush || (r_cnt == TO_LAST));
        w_in_ready   = w_issue_pair;
        if (w_issue_pair) begin
          w_mult  = {in_a[3:0], r_hold.a_nib};
          w_mcand = {in_b[3:0], r_hold.b_nib};
          w_lanes = LANES_PAIR;
        end else begin
          w_mult  = {4'b0000, r_hold.a_nib};
          w_mcand = {4'b0000, r_hold.b_nib};
          w_lanes = LANES_LONE;
        end
      end
      default: ;
    endcase
  end

  assign w_issue = w_issue_full || w_issue_pair || w_issue_lone;

  config_multiplier_8bit u_mult (
    .multiplier      (w_mult),
    .multiplicand    (w_mcand),
    .halvedPrecision (w_halved),
    .product         (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_cnt  <= '0;
    end else if (w_hold_load) begin
      r_hold <= '{a_nib: in_a[3:0], b_nib: in_b[3:0]};
      r_cnt  <= '0;
    end else if (w_issue_pair || w_issue_lone) begin
      r_cnt  <= '0;
    end else if (r_state == HALF_HELD && r_cnt != TO_LAST) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_out_half    <= 1'b0;
      r_out_lanes   <= 2'b00;
    end else if (w_issue) begin
      r_out_valid   <= 1'b1;
      r_out_product <= w_product;
      r_out_half    <= w_halved;
      r_out_lanes   <= w_lanes;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

`ifdef MULT_PAIR_STATS_EN
  logic [CNT_W-1:0] r_stat_full, r_stat_pair, r_stat_lone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_full <= '0;
      r_stat_pair <= '0;
      r_stat_lone <= '0;
    end else begin
      if (w_issue_full) r_stat_full <= r_stat_full + 1'b1;
      if (w_issue_pair) r_stat_pair <= r_stat_pair + 1'b1;
      if (w_issue_lone) r_stat_lone <= r_stat_lone + 1'b1;
    end
  end

  assign stat_full = r_stat_full;
  assign stat_pair = r_stat_pair;
  assign stat_lone = r_stat_lone;
`endif

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign out_half    = r_out_half;
  assign out_lanes   = r_out_lanes;
endmodule

// File: tb/tb_mult_pair_scheduler.sv
// Bench for mult_pair_scheduler: scenario tasks push expected results, a monitor
// pops and compares them on every output handshake.
module tb_mult_pair_scheduler;
  localparam int TO = 8;

  logic        clk, rst_n, in_valid, in_ready, in_half, flush;
  logic        out_valid, out_ready, out_half;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_product;
  logic [1:0]  out_lanes;
`ifdef MULT_PAIR_STATS_EN
  logic [15:0] stat_full, stat_pair, stat_lone;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] exp_q[$];

  mult_pair_scheduler #(.FLUSH_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_half     (in_half),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_half    (out_half),
    .out_lanes   (out_lanes)
`ifdef MULT_PAIR_STATS_EN
    , .stat_full (stat_full)
    , .stat_pair (stat_pair)
    , .stat_lone (stat_lone)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arithmetic, written from two's-complement definitions
  function automatic logic [18:0] exp_full(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, p;
    logic [31:0] v;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    p = sa * sb;
    v = p;
    return {2'b11, 1'b0, v[15:0]};
  endfunction

  function automatic logic [7:0] half_prod(input logic [3:0] a, input logic [3:0] b);
    int sa, sb, p;
    logic [31:0] v;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    p = sa * sb;
    v = p;
    return v[7:0];
  endfunction

  function automatic logic [18:0] exp_pair(input logic [3:0] a0, input logic [3:0] b0,
                                           input logic [3:0] a1, input logic [3:0] b1);
    return {2'b11, 1'b1, half_prod(a1, b1), half_prod(a0, b0)};
  endfunction

  function automatic logic [18:0] exp_lone(input logic [3:0] a, input logic [3:0] b);
    return {2'b01, 1'b1, 8'h00, half_prod(a, b)};
  endfunction

  // Scoreboard: the handshake completes at the next rising edge
  always @(negedge clk) begin
    logic [18:0] got, exp;
    if (rst_n && out_valid && out_ready) begin
      got = {out_lanes, out_half, out_product};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_unexpected got=%h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL scoreboard_result got=%h required=%h", got, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic half);
    int t;
    t = 0;
    in_a = a; in_b = b; in_half = half; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL send_accept in_ready=0 for 50 cycles required=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output int left);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    tick(2);
    left = exp_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_half = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got=%b required=0", out_valid);
    end
    n_cmp++;
    if ({out_lanes, out_half, out_product} !== 19'h0) begin
      n_err++; $display("FAIL reset_payload got=%h required=0", {out_lanes, out_half, out_product});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    logic [7:0] ta[6], tb_v[6];
    logic [7:0] ra, rb;
    int left;
    ta   = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h9C};
    tb_v = '{8'h80, 8'h80, 8'h55, 8'hFF, 8'h7F, 8'h64};
    out_ready = 1'b1;
    exp_q.push_back(exp_full(8'hFD, 8'h07));
    send(8'hFD, 8'h07, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_product !== 16'hFFEB || out_half !== 1'b0 || out_lanes !== 2'b11) begin
      n_err++;
      $display("FAIL full_latency got v=%b p=%h h=%b l=%b required v=1 p=ffeb h=0 l=11",
               out_valid, out_product, out_half, out_lanes);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exp_full(ta[i], tb_v[i]));
      send(ta[i], tb_v[i], 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(exp_full(ra, rb));
      send(ra, rb, 1'b0);
    end
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL full_drain outstanding=%0d required=0", left);
    end
  endtask

  task automatic test_pair();
    logic [7:0] a0, b0, a1, b1;
    int left;
    out_ready = 1'b1;
    exp_q.push_back(exp_pair(4'h3, 4'hE, 4'hC, 4'h5));
    send(8'hA3, 8'hFE, 1'b1);
    send(8'h5C, 8'h35, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (out_product !== 16'hECFA || out_lanes !== 2'b11 || out_half !== 1'b1) begin
      n_err++;
      $display("FAIL pair_basic got p=%h l=%b h=%b required p=ecfa l=11 h=1", out_product, out_lanes, out_half);
    end
    @(posedge clk); #1;
    exp_q.push_back(exp_pair(4'h8, 4'h8, 4'h7, 4'h8));
    send(8'h08, 8'h08, 1'b1);
    send(8'h07, 8'h08, 1'b1);
    for (int i = 0; i < 6; i++) begin
      a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
      exp_q.push_back(exp_pair(a0[3:0], b0[3:0], a1[3:0], b1[3:0]));
      send(a0, b0, 1'b1);
      send(a1, b1, 1'b1);
    end
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL pair_drain outstanding=%0d required=0", left);
    end
  endtask

  task automatic test_timeout();
    int cyc, left;
    cyc = -1;
    out_ready = 1'b1;
    exp_q.push_back(exp_lone(4'h2, 4'h3));
    send(8'h02, 8'h03, 1'b1);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = j - 1;
        break;
      end
    end
    n_cmp++;
    if (cyc !== TO) begin
      n_err++; $display("FAIL timeout_latency got=%0d required=%0d", cyc, TO);
    end
    n_cmp++;
    if (out_product !== 16'h0006 || out_lanes !== 2'b01) begin
      n_err++; $display("FAIL timeout_lone got p=%h l=%b required p=0006 l=01", out_product, out_lanes);
    end
    @(posedge clk); #1;
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL timeout_drain outstanding=%0d required=0", left);
    end
  endtask

  task automatic test_flush();
    int left;
    out_ready = 1'b1;
    flush = 1'b1;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_empty got out_valid=%b required=0", out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.push_back(exp_lone(4'h7, 4'h1));
    send(8'h07, 8'h01, 1'b1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_lanes !== 2'b01 || out_product !== 16'h0007) begin
      n_err++;
      $display("FAIL flush_lone got v=%b l=%b p=%h required v=1 l=01 p=0007", out_valid, out_lanes, out_product);
    end
    @(posedge clk); #1;
    exp_q.push_back(exp_pair(4'h1, 4'h2, 4'h3, 4'h3));
    send(8'h01, 8'h02, 1'b1);
    flush = 1'b1;
    send(8'h03, 8'h03, 1'b1);
    flush = 1'b0;
    exp_q.push_back(exp_pair(4'h6, 4'h1, 4'h2, 4'h2));
    send(8'h06, 8'h01, 1'b1);
    tick(TO - 1);
    send(8'h02, 8'h02, 1'b1);
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL flush_drain outstanding=%0d required=0", left);
    end
  endtask

  task automatic test_full_after_half();
    int left;
    out_ready = 1'b1;
    exp_q.push_back(exp_lone(4'h1, 4'h1));
    exp_q.push_back(exp_full(8'd10, 8'd10));
    send(8'h01, 8'h01, 1'b1);
    in_a = 8'd10; in_b = 8'd10; in_half = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL stall_ready got=%b required=0", in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_release got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL stall_drain outstanding=%0d required=0", left);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    logic [18:0] e1;
    int left;
    a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    a2 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
    e1 = exp_full(a1, b1);
    exp_q.push_back(e1);
    out_ready = 1'b0;
    send(a1, b1, 1'b0);
    exp_q.push_back(exp_full(a2, b2));
    in_a = a2; in_b = b2; in_half = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_ready cycle=%0d got=%b required=0", i, in_ready);
      end
      n_cmp++;
      if ({out_valid, out_lanes, out_half, out_product} !== {1'b1, e1}) begin
        n_err++;
        $display("FAIL bp_stable cycle=%0d got=%h required=%h", i,
                 {out_valid, out_lanes, out_half, out_product}, {1'b1, e1});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_resume got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL bp_drain outstanding=%0d required=0", left);
    end
  endtask

  task automatic test_reset_mid();
    int left;
    out_ready = 1'b0;
    send(8'h11, 8'h02, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_valid got=%b required=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_lanes, out_half, out_product} !== 20'h0) begin
      n_err++;
      $display("FAIL rst_async got=%h required=0", {out_valid, out_lanes, out_half, out_product});
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    send(8'h05, 8'h05, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_discard got out_valid=%b required=0", out_valid);
    end
    @(posedge clk); #1;
    exp_q.push_back(exp_full(8'd3, 8'd4));
    send(8'd3, 8'd4, 1'b0);
    wait_drain(left);
    n_cmp++;
    if (left !== 0) begin
      n_err++; $display("FAIL rst_drain outstanding=%0d required=0", left);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_pair();
    test_timeout();
    test_flush();
    test_full_after_half();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mult_pair_scheduler.md
Name: mult_pair_scheduler

Overview:
- Streaming front-end that sequences operand pairs into one `config_multiplier_8bit` instance and drives its `halvedPrecision` input.
- Full-precision requests (signed 8x8) issue alone.
- Half-precision requests (signed 4x4) are buffered and packed two per issue to use both lanes.
- Results return on a valid/ready stream with lane-occupancy tags. Sits between the operand fetch and the accumulator stage.

Parameters:
- FLUSH_TIMEOUT, 8, cycles a lone buffered half op waits for a partner before it issues alone (range 1..255).
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_a  input  8  multiplier operand; half mode uses [3:0] only
- in_b  input  8  multiplicand operand; half mode uses [3:0] only
- in_half  input  1  1 = signed 4x4 request, 0 = signed 8x8 request
- flush  input  1  force immediate issue of a buffered half op
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_product  output  16  full: signed 16-bit product; half: [7:0] lane0, [15:8] lane1
- out_half  output  1  result was a half-precision issue
- out_lanes  output  2  lane-valid mask (full: 2'b11; pair: 2'b11; lone half: 2'b01)

Behaviour:
- Reset (async, rst_n=0) forces:
  - out_valid=0, out_product=0, out_half=0, out_lanes=0.
  - State EMPTY, hold register cleared, timeout counter 0.
  - A pending half op is discarded.
- Clock and reset: single domain clk; rst_n asynchronous assert, synchronous deassert handled upstream.
- Output slot:
  - One output register; `can_issue = !out_valid || out_ready`.
  - Result register loads on issue; out_valid clears on consume without a new issue.
- Datapath:
  - The multiplier is combinational, fed from a mux of input and hold register. Result registered, so latency is 1 cycle from the completing accept to out_valid.
- FSM states: EMPTY, HALF_HELD.
- EMPTY:
  - in_ready = can_issue.
  - Full request accepted: issue {in_a,in_b}, halvedPrecision=0, next state EMPTY.
  - Half request accepted: store nibbles in the hold register, no issue, counter=0, next state HALF_HELD.
- HALF_HELD, half request, can_issue:
  - in_ready=1.
  - Issue lane0=held op, lane1=new op: multiplier = {new_a[3:0], held_a[3:0]}, multiplicand likewise, halvedPrecision=1, out_lanes=2'b11.
  - Next state EMPTY.
- HALF_HELD, any flush trigger and can_issue:
  - Triggers: full request pending, flush=1, or counter==FLUSH_TIMEOUT-1.
  - in_ready=0.
  - Issue held op alone: upper nibbles zero, halvedPrecision=1, out_lanes=2'b01.
  - Next state EMPTY. A stalled full request is accepted the following cycle.
- Priority in HALF_HELD: a pairing half request wins over timeout and flush in the same cycle.
- HALF_HELD, !can_issue: in_ready=0, hold register kept, counter saturates at FLUSH_TIMEOUT-1.
- HALF_HELD, otherwise: counter increments each cycle.
- flush in EMPTY: no effect.
- Arithmetic:
  - Full mode: two's-complement 8x8 into 16 bits.
  - Half mode: each lane is a signed 4x4 into an 8-bit two's-complement result, independent of the other lane.
- Output stability: out_product, out_half and out_lanes hold while out_valid && !out_ready.

Optional Feature:
- Macro: MULT_PAIR_STATS_EN.
- When defined, adds outputs stat_full, stat_pair, stat_lone (each CNT_W bits).
  - Each counts issues of its kind and wraps at 2^CNT_W.
  - Reset to 0 by rst_n.
- When undefined, these ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package mult_sched_pkg holds:
  - typedef enum logic {EMPTY, HALF_HELD} sched_state_t
  - typedef struct for the hold register {a_nib, b_nib}
  - localparams LANE_W=4 and PROD_W=16
  - lane-mask constants LANES_FULL, LANES_PAIR, LANES_LONE
- Sub-module: the existing config_multiplier_8bit, instantiated once. No other sub-module is needed.

Test Plan:
- Full op a=-3 (8'hFD), b=7, out_ready=1 → next cycle out_product=16'hFFEB (-21), out_half=0, out_lanes=2'b11.
- Half ops (a=3,b=-2) then (a=-4,b=5) back-to-back → one result: [7:0]=8'hFA (-6), [15:8]=8'hEC (-20), out_lanes=2'b11.
- Half op (a=2,b=3), no partner, FLUSH_TIMEOUT=8 → lone result exactly 8 cycles after accept: [7:0]=8'h06, [15:8]=0, out_lanes=2'b01.
- Half op held, then full op (a=10,b=10) → in_ready=0 for one cycle; lone half issued first, then 16'd100 next.
- out_ready=0 for 5 cycles with out_valid=1 → in_ready=0 whenever an issue is needed, output stable; no result lost or duplicated after out_ready rises.
- rst_n asserted while HALF_HELD and out_valid=1 → out_valid=0 immediately (async); after release, the held op never appears.
